// File: rtl/pwm_pkg.sv
// Types and constants shared between the duty ramp and the PWM generator it feeds.
package pwm_pkg;

  localparam int DUTY_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } ramp_state_e;

  function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] value,
                                                   input logic [DUTY_W-1:0] limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running divider that fires one tick every TICK_DIV enabled clocks.
module tick_divider #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign tick = enable && !clear && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pwm_duty_ramp.sv
// Slews the PWM duty toward an accepted target in STEP increments, one step per tick.
module pwm_duty_ramp
  import pwm_pkg::*;
#(
  parameter int PERIOD   = 100,
  parameter int STEP     = 1,
  parameter int TICK_DIV = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DUTY_W-1:0] target,
  input  logic              target_valid,
  output logic              target_ready,
  output logic [DUTY_W-1:0] duty,
  output logic              update,
  output logic              busy
);

  localparam logic [DUTY_W-1:0] PERIOD_V = DUTY_W'(PERIOD);
  localparam logic [DUTY_W-1:0] STEP_V   = DUTY_W'(STEP);

  ramp_state_e       state_q;
  logic [DUTY_W-1:0] duty_q;
  logic [DUTY_W-1:0] target_q;
  logic              update_q;

  logic              accept;
  logic              tick;
  logic [DUTY_W-1:0] target_clamped;
  logic [DUTY_W-1:0] distance;
  logic              going_up;

  assign accept         = target_valid && (state_q == IDLE);
  assign target_clamped = clamp_duty(target, PERIOD_V);

  // Compare first so the subtraction never wraps.
  assign going_up = (target_q >= duty_q);
  assign distance = going_up ? (target_q - duty_q) : (duty_q - target_q);

  tick_divider #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_divider (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .enable(state_q == RAMP),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      duty_q   <= '0;
      target_q <= '0;
      update_q <= 1'b0;
    end else begin
      update_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            target_q <= target_clamped;
            if (target_clamped != duty_q) begin
              state_q <= RAMP;
            end
          end
        end
        RAMP: begin
          if (tick) begin
            update_q <= 1'b1;
            // Final step lands exactly on the target so duty never overshoots.
            if (distance <= STEP_V) begin
              duty_q  <= target_q;
              state_q <= IDLE;
            end else if (going_up) begin
              duty_q <= duty_q + STEP_V;
            end else begin
              duty_q <= duty_q - STEP_V;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign target_ready = (state_q == IDLE);
  assign busy         = (state_q == RAMP);
  assign duty         = duty_q;
  assign update       = update_q;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Self-checking bench for pwm_duty_ramp: table vectors, random targets, and hand-written corner sequences.
module tb_pwm_duty_ramp;

  localparam int PERIOD   = 100;
  localparam int STEP     = 10;
  localparam int TICK_DIV = 4;

  logic        clk;
  logic        reset;
  logic [15:0] target;
  logic        target_valid;
  logic        target_ready;
  logic [15:0] duty;
  logic        update;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int model_duty = 0;

  pwm_duty_ramp #(
    .PERIOD  (PERIOD),
    .STEP    (STEP),
    .TICK_DIV(TICK_DIV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .target      (target),
    .target_valid(target_valid),
    .target_ready(target_ready),
    .duty        (duty),
    .update      (update),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    model_duty = 0;
    check("reset_duty", int'(duty), 0);
    check("reset_update", int'(update), 0);
    check("reset_ready", int'(target_ready), 1);
    check("reset_busy", int'(busy), 0);
    $display("txn reset: duty=%0d ready=%0d busy=%0d", duty, target_ready, busy);
  endtask

  // Reference: the expected duty sequence is the list of values visited when
  // walking from the current duty toward min(target, PERIOD) in STEP strides,
  // landing exactly on the target; each value appears TICK_DIV clocks apart.
  task automatic apply_target(input int tgt, input bit inject,
                              output int final_duty, output int pulses);
    int ct, d, start, n, k, exp_upd, exp_duty, exp_busy;
    int seq[$];
    ct = (tgt > PERIOD) ? PERIOD : tgt;
    start = model_duty;
    d = start;
    seq = {};
    while (d != ct) begin
      if (d < ct) d = (ct - d <= STEP) ? ct : d + STEP;
      else        d = (d - ct <= STEP) ? ct : d - STEP;
      seq.push_back(d);
    end
    n = seq.size();
    pulses = 0;
    check("ready_before_accept", int'(target_ready), 1);
    target = 16'(tgt);
    target_valid = 1'b1;
    step();
    target_valid = 1'b0;
    check("busy_after_accept", int'(busy), (n > 0) ? 1 : 0);
    check("update_at_accept", int'(update), 0);
    for (int c = 1; c <= n * TICK_DIV + 2; c++) begin
      if (inject && n > 0 && c == 2) begin
        target = 16'd90;
        target_valid = 1'b1;
      end
      step();
      target_valid = 1'b0;
      pulses += int'(update);
      k = c / TICK_DIV;
      if (k > n) k = n;
      exp_upd  = ((c % TICK_DIV) == 0 && (c / TICK_DIV) <= n) ? 1 : 0;
      exp_duty = (k == 0) ? start : seq[k-1];
      exp_busy = (c < n * TICK_DIV) ? 1 : 0;
      check("update", int'(update), exp_upd);
      check("duty", int'(duty), exp_duty);
      check("busy", int'(busy), exp_busy);
      check("ready", int'(target_ready), 1 - exp_busy);
    end
    model_duty = ct;
    final_duty = int'(duty);
    $display("txn target=%0d from=%0d final_duty=%0d pulses=%0d inject=%0d",
             tgt, start, final_duty, pulses, inject);
  endtask

  typedef struct {
    int tgt;
    int exp_final;
    int exp_pulses;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int fd, np, guard;
    vecs[0] = '{tgt: 50,  exp_final: 50,  exp_pulses: 5};
    vecs[1] = '{tgt: 200, exp_final: 100, exp_pulses: 5};
    vecs[2] = '{tgt: 200, exp_final: 100, exp_pulses: 0};
    vecs[3] = '{tgt: 5,   exp_final: 5,   exp_pulses: 10};
    vecs[4] = '{tgt: 50,  exp_final: 50,  exp_pulses: 5};
    vecs[5] = '{tgt: 5,   exp_final: 5,   exp_pulses: 5};
    vecs[6] = '{tgt: 0,   exp_final: 0,   exp_pulses: 1};

    reset = 1'b1;
    target = '0;
    target_valid = 1'b0;
    do_reset();

    for (int i = 0; i < 7; i++) begin
      apply_target(vecs[i].tgt, 1'b0, fd, np);
      check("vec_final_duty", fd, vecs[i].exp_final);
      check("vec_pulses", np, vecs[i].exp_pulses);
    end

    // Busy-ignore: a target offered mid-ramp must not redirect the ramp.
    apply_target(50, 1'b1, fd, np);
    check("ignore_final_duty", fd, 50);
    check("ignore_pulses", np, 5);

    // Mid-ramp reset at duty=30.
    do_reset();
    target = 16'd50;
    target_valid = 1'b1;
    step();
    target_valid = 1'b0;
    guard = 0;
    while (int'(duty) != 30 && guard < 40) begin
      step();
      guard++;
    end
    check("midreset_reach30", int'(duty), 30);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset_duty", int'(duty), 0);
    check("midreset_update", int'(update), 0);
    check("midreset_ready", int'(target_ready), 1);
    check("midreset_busy", int'(busy), 0);
    for (int c = 0; c < 6; c++) begin
      step();
      check("midreset_idle_update", int'(update), 0);
      check("midreset_idle_duty", int'(duty), 0);
    end
    model_duty = 0;
    $display("txn mid-ramp reset: duty=%0d busy=%0d", duty, busy);

    // Randomised targets against the reference sequence.
    for (int i = 0; i < 25; i++) begin
      int t;
      bit inj;
      t = (($urandom_range(0, 3)) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 150));
      inj = ($urandom_range(0, 3) == 0);
      apply_target(t, inj, fd, np);
      check("rand_final_duty", fd, (t > PERIOD) ? PERIOD : t);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
